// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RV32I definitions used by the decode-stage controller:
//   - major opcode constants (bits 6:0 of an instruction)
//   - immediate-type select encodings that drive the immediate generator
//   - the skid-buffer state enumeration
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam logic [2:0] IMM_NONE = 3'b000;
   localparam logic [2:0] IMM_I    = 3'b001;
   localparam logic [2:0] IMM_S    = 3'b010;
   localparam logic [2:0] IMM_B    = 3'b011;
   localparam logic [2:0] IMM_U    = 3'b100;
   localparam logic [2:0] IMM_J    = 3'b101;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_t;

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder
// Purely combinational decode of an RV32I major opcode.
// Ports:
//   opcode   in  7  instruction bits 6:0
//   imm_type out 3  immediate-type select (IMM_* encodings)
//   uses_rs1 out 1  instruction reads rs1 (bits 19:15)
//   uses_rs2 out 1  instruction reads rs2 (bits 24:20)
//   illegal  out 1  opcode is not an RV32I major opcode
module opcode_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [2:0] imm_type,
   output logic       uses_rs1,
   output logic       uses_rs2,
   output logic       illegal
);

   always_comb begin
      imm_type = IMM_NONE;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_FENCE: begin
            imm_type = IMM_I;
            uses_rs1 = 1'b1;
         end
         OPC_STORE: begin
            imm_type = IMM_S;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OPC_BRANCH: begin
            imm_type = IMM_B;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
         OPC_JAL:            imm_type = IMM_J;
         OPC_OP: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         // Unknown opcodes read no registers so they can never stall.
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_stage_controller.sv
// id_stage_controller
// Decode-stage controller: 2-entry skid buffer between fetch and execute,
// immediate-type decode of the head instruction, load-use hazard stall and
// pipeline flush.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal_out reflects decode when
// defined, tied to 0 otherwise).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_valid_in/if_instr_in/if_pc_in/if_ready_out   fetch handshake
//   flush_in            discard all buffered entries
//   ex_ready_in         execute accepts the decode output
//   ex_is_load_in/ex_rd_in  load in execute and its destination
//   id_valid_out/id_instr_out/id_pc_out  head entry presented to execute
//   imm_type_out        immediate select of head
//   illegal_out         head opcode is illegal
module id_stage_controller
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_valid_in,
   input  logic [31:0] if_instr_in,
   input  logic [31:0] if_pc_in,
   output logic        if_ready_out,
   input  logic        flush_in,
   input  logic        ex_ready_in,
   input  logic        ex_is_load_in,
   input  logic [4:0]  ex_rd_in,
   output logic        id_valid_out,
   output logic [31:0] id_instr_out,
   output logic [31:0] id_pc_out,
   output logic [2:0]  imm_type_out,
   output logic        illegal_out
);

   buf_state_t  state;
   logic [31:0] head_instr, head_pc;
   logic [31:0] tail_instr, tail_pc;

   logic [2:0]  dec_imm_type;
   logic        dec_uses_rs1, dec_uses_rs2, dec_illegal;
   logic        hazard, push, pop;

   opcode_decoder u_dec (
      .opcode   (head_instr[6:0]),
      .imm_type (dec_imm_type),
      .uses_rs1 (dec_uses_rs1),
      .uses_rs2 (dec_uses_rs2),
      .illegal  (dec_illegal)
   );

   // Load-use hazard against the head's source registers; x0 never stalls.
   assign hazard = ex_is_load_in && (ex_rd_in != 5'd0) &&
                   ((dec_uses_rs1 && (head_instr[19:15] == ex_rd_in)) ||
                    (dec_uses_rs2 && (head_instr[24:20] == ex_rd_in)));

   assign id_valid_out = (state != ST_EMPTY) && !hazard;
   assign push         = if_valid_in && if_ready_out;
   assign pop          = id_valid_out && ex_ready_in;

   assign id_instr_out = head_instr;
   assign id_pc_out    = head_pc;
   assign imm_type_out = dec_imm_type;

`ifdef ILLEGAL_TRAP_EN
   // Gated by occupancy so an empty buffer never reports a stale trap.
   assign illegal_out = dec_illegal && (state != ST_EMPTY);
`else
   // Illegal opcodes pass through as ordinary instructions; the decode
   // result is intentionally discarded.
   assign illegal_out = dec_illegal & 1'b0;
`endif

   // Buffer FSM; if_ready_out is registered and low only while holding two.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_EMPTY;
         if_ready_out <= 1'b1;
         head_instr   <= '0;
         head_pc      <= '0;
         tail_instr   <= '0;
         tail_pc      <= '0;
      end else if (flush_in) begin
         state        <= ST_EMPTY;
         if_ready_out <= 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  head_instr <= if_instr_in;
                  head_pc    <= if_pc_in;
                  state      <= ST_ONE;
               end
               if_ready_out <= 1'b1;
            end
            ST_ONE: begin
               if (push && pop) begin
                  // Head leaves as the new entry arrives: new entry is head.
                  head_instr   <= if_instr_in;
                  head_pc      <= if_pc_in;
                  if_ready_out <= 1'b1;
               end else if (push) begin
                  tail_instr   <= if_instr_in;
                  tail_pc      <= if_pc_in;
                  state        <= ST_TWO;
                  if_ready_out <= 1'b0;
               end else if (pop) begin
                  state        <= ST_EMPTY;
                  if_ready_out <= 1'b1;
               end else begin
                  if_ready_out <= 1'b1;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  head_instr   <= tail_instr;
                  head_pc      <= tail_pc;
                  state        <= ST_ONE;
                  if_ready_out <= 1'b1;
               end else begin
                  if_ready_out <= 1'b0;
               end
            end
            default: begin
               state        <= ST_EMPTY;
               if_ready_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_id_stage_controller.sv
module tb_id_stage_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid_in;
   logic [31:0] if_instr_in;
   logic [31:0] if_pc_in;
   logic        if_ready_out;
   logic        flush_in;
   logic        ex_ready_in;
   logic        ex_is_load_in;
   logic [4:0]  ex_rd_in;
   logic        id_valid_out;
   logic [31:0] id_instr_out;
   logic [31:0] id_pc_out;
   logic [2:0]  imm_type_out;
   logic        illegal_out;

   id_stage_controller dut (
      .clk           (clk),
      .rst           (rst),
      .if_valid_in   (if_valid_in),
      .if_instr_in   (if_instr_in),
      .if_pc_in      (if_pc_in),
      .if_ready_out  (if_ready_out),
      .flush_in      (flush_in),
      .ex_ready_in   (ex_ready_in),
      .ex_is_load_in (ex_is_load_in),
      .ex_rd_in      (ex_rd_in),
      .id_valid_out  (id_valid_out),
      .id_instr_out  (id_instr_out),
      .id_pc_out     (id_pc_out),
      .imm_type_out  (imm_type_out),
      .illegal_out   (illegal_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t sb[$];
   int     n_vec = 0;
   int     n_err = 0;
   logic   accepted;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] model_imm(input logic [31:0] ins);
      case (ins[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: return 3'b001;
         7'b0100011: return 3'b010;
         7'b1100011: return 3'b011;
         7'b0110111, 7'b0010111: return 3'b100;
         7'b1101111: return 3'b101;
         default:    return 3'b000;
      endcase
   endfunction

   function automatic logic model_illegal(input logic [31:0] ins);
`ifdef ILLEGAL_TRAP_EN
      case (ins[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111,
         7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
         7'b0110011: return 1'b0;
         default:    return 1'b1;
      endcase
`else
      return 1'b0 & ins[0];
`endif
   endfunction

   // One clock: observe handshakes at the falling edge, update the scoreboard,
   // then return just after the next rising edge for the driver.
   task automatic cycle();
      entry_t e;
      @(negedge clk);
      accepted = 1'b0;
      if (rst || flush_in) begin
         sb.delete();
      end else begin
         if (id_valid_out && ex_ready_in) begin
            if (sb.size() == 0) begin
               check("unexpected_issue", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("issue_instr", id_instr_out, e.instr);
               check("issue_pc", id_pc_out, e.pc);
               check("issue_imm", {29'd0, imm_type_out}, {29'd0, model_imm(e.instr)});
               check("issue_illegal", {31'd0, illegal_out}, {31'd0, model_illegal(e.instr)});
            end
         end
         if (if_valid_in && if_ready_out) begin
            e.instr = if_instr_in;
            e.pc    = if_pc_in;
            sb.push_back(e);
            accepted = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      if_valid_in = 1'b0;
      ex_ready_in = 1'b1;
      for (int k = 0; k < budget && sb.size() != 0; k++) cycle();
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin
      rst = 1'b1; if_valid_in = 1'b0; if_instr_in = '0; if_pc_in = '0;
      flush_in = 1'b0; ex_ready_in = 1'b0; ex_is_load_in = 1'b0; ex_rd_in = '0;
      cycle(); cycle();
      rst = 1'b0;
      #1;
      check("rst_ready", {31'd0, if_ready_out}, 32'd1);
      check("rst_valid", {31'd0, id_valid_out}, 32'd0);
      check("rst_instr", id_instr_out, 32'd0);
      check("rst_pc", id_pc_out, 32'd0);
      check("rst_imm", {29'd0, imm_type_out}, 32'd0);
      check("rst_illegal", {31'd0, illegal_out}, 32'd0);

      // Single ADDI: valid one cycle after the push.
      ex_ready_in = 1'b1;
      if_valid_in = 1'b1; if_instr_in = 32'h00500093; if_pc_in = 32'h100;
      cycle();
      if_valid_in = 1'b0;
      check("lat_valid", {31'd0, id_valid_out}, 32'd1);
      check("lat_imm", {29'd0, imm_type_out}, 32'd1);
      check("lat_instr", id_instr_out, 32'h00500093);
      drain(5);

      // Back-to-back SW, BEQ, JAL with no bubbles.
      if_valid_in = 1'b1; if_instr_in = 32'h0020A023; if_pc_in = 32'h200;
      cycle();
      check("b2b_v0", {31'd0, id_valid_out}, 32'd1);
      check("b2b_imm0", {29'd0, imm_type_out}, 32'd2);
      if_instr_in = 32'h00208063; if_pc_in = 32'h204;
      cycle();
      check("b2b_v1", {31'd0, id_valid_out}, 32'd1);
      check("b2b_imm1", {29'd0, imm_type_out}, 32'd3);
      if_instr_in = 32'h008000EF; if_pc_in = 32'h208;
      cycle();
      if_valid_in = 1'b0;
      check("b2b_v2", {31'd0, id_valid_out}, 32'd1);
      check("b2b_imm2", {29'd0, imm_type_out}, 32'd5);
      drain(5);

      // Backpressure: third push refused while full, order kept.
      ex_ready_in = 1'b0;
      if_valid_in = 1'b1; if_instr_in = 32'h00100113; if_pc_in = 32'h300;
      cycle();
      if_instr_in = 32'h00200193; if_pc_in = 32'h304;
      cycle();
      if_instr_in = 32'h00300213; if_pc_in = 32'h308;
      check("full_ready", {31'd0, if_ready_out}, 32'd0);
      cycle();
      check("full_refused", {31'd0, accepted}, 32'd0);
      check("full_head", id_instr_out, 32'h00100113);
      ex_ready_in = 1'b1;
      accepted = 1'b0;
      for (int k = 0; k < 10 && !accepted; k++) cycle();
      check("full_third_taken", {31'd0, accepted}, 32'd1);
      drain(6);

      // Load-use hazard on rs2 of ADD x3,x1,x2.
      if_valid_in = 1'b1; if_instr_in = 32'h002081B3; if_pc_in = 32'h400;
      ex_is_load_in = 1'b1; ex_rd_in = 5'd2;
      cycle();
      if_valid_in = 1'b0;
      check("haz_stall", {31'd0, id_valid_out}, 32'd0);
      cycle();
      check("haz_hold", {31'd0, id_valid_out}, 32'd0);
      ex_rd_in = 5'd1; #1;
      check("haz_rs1", {31'd0, id_valid_out}, 32'd0);
      ex_is_load_in = 1'b0; #1;
      check("haz_release", {31'd0, id_valid_out}, 32'd1);
      cycle();
      check("haz_issued", sb.size(), 0);
      // Same stimulus with rd = x0: no stall.
      if_valid_in = 1'b1; if_instr_in = 32'h002081B3; if_pc_in = 32'h404;
      ex_is_load_in = 1'b1; ex_rd_in = 5'd0;
      cycle();
      if_valid_in = 1'b0;
      check("haz_x0", {31'd0, id_valid_out}, 32'd1);
      cycle();
      ex_is_load_in = 1'b0;
      drain(5);

      // Flush in TWO with a simultaneous push.
      ex_ready_in = 1'b0;
      if_valid_in = 1'b1; if_instr_in = 32'h00100113; if_pc_in = 32'h500;
      cycle();
      if_instr_in = 32'h00200193; if_pc_in = 32'h504;
      cycle();
      check("fl_full", {31'd0, if_ready_out}, 32'd0);
      flush_in = 1'b1; if_instr_in = 32'h00300213; if_pc_in = 32'h508;
      cycle();
      flush_in = 1'b0; if_valid_in = 1'b0;
      check("fl_valid", {31'd0, id_valid_out}, 32'd0);
      check("fl_ready", {31'd0, if_ready_out}, 32'd1);
      ex_ready_in = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      check("fl_still_empty", {31'd0, id_valid_out}, 32'd0);

      // Illegal opcode.
      if_valid_in = 1'b1; if_instr_in = 32'h0000007F; if_pc_in = 32'h600;
      cycle();
      if_valid_in = 1'b0;
      check("ill_imm", {29'd0, imm_type_out}, 32'd0);
      check("ill_flag", {31'd0, illegal_out}, {31'd0, model_illegal(32'h0000007F)});
      check("ill_valid", {31'd0, id_valid_out}, 32'd1);
      drain(5);

      // Reset mid-operation discards everything.
      ex_ready_in = 1'b0;
      if_valid_in = 1'b1; if_instr_in = 32'h00100113; if_pc_in = 32'h700;
      cycle();
      if_instr_in = 32'h00200193; if_pc_in = 32'h704;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0; if_valid_in = 1'b0;
      check("mrst_valid", {31'd0, id_valid_out}, 32'd0);
      check("mrst_ready", {31'd0, if_ready_out}, 32'd1);
      ex_ready_in = 1'b1;
      cycle(); cycle();
      check("final_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
